// File: rtl/atm_session_if.sv
// Request/response port of the ATM session controller: a valid/ready request
// channel, an abort line and a registered one-cycle response.
interface atm_session_if #(
    parameter int ACC_W = 12,
    parameter int PIN_W = 4,
    parameter int BAL_W = 16,
    parameter int AMT_W = 11
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       op;
    logic [ACC_W-1:0] acc_number;
    logic [PIN_W-1:0] pin;
    logic [ACC_W-1:0] dest_acc;
    logic [AMT_W-1:0] amount;
    logic             exit;
    logic             resp_valid;
    logic [2:0]       resp_code;
    logic [BAL_W-1:0] balance;
    logic             authed;

    modport master (
        output req_valid, op, acc_number, pin, dest_acc, amount, exit,
        input  req_ready, resp_valid, resp_code, balance, authed
    );

    modport slave (
        input  req_valid, op, acc_number, pin, dest_acc, amount, exit,
        output req_ready, resp_valid, resp_code, balance, authed
    );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM session controller: provisioned account table, PIN login with lockout and
// balance/withdraw/deposit/transfer with fixed, data-independent latency.
module atm_session_ctrl #(
    parameter int NUM_ACC   = 10,
    parameter int ACC_W     = 12,
    parameter int PIN_W     = 4,
    parameter int BAL_W     = 16,
    parameter int AMT_W     = 11,
    parameter int MAX_TRIES = 3,
    parameter int INIT_BAL  = 500,
    localparam int IDX_W    = $clog2(NUM_ACC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prov_we,
    input  logic [IDX_W-1:0] prov_idx,
    input  logic [ACC_W-1:0] prov_acc,
    input  logic [PIN_W-1:0] prov_pin,
    atm_session_if.slave     bus
);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);

    localparam logic [2:0] OP_LOGIN    = 3'd0;
    localparam logic [2:0] OP_BALANCE  = 3'd1;
    localparam logic [2:0] OP_WITHDRAW = 3'd2;
    localparam logic [2:0] OP_DEPOSIT  = 3'd3;
    localparam logic [2:0] OP_TRANSFER = 3'd4;
    localparam logic [2:0] OP_LOGOUT   = 3'd5;

    localparam logic [2:0] RC_OK       = 3'd0;
    localparam logic [2:0] RC_BAD_CRED = 3'd1;
    localparam logic [2:0] RC_LOCKED   = 3'd2;
    localparam logic [2:0] RC_INSUFF   = 3'd3;
    localparam logic [2:0] RC_OVERFLOW = 3'd4;
    localparam logic [2:0] RC_NO_DEST  = 3'd5;
    localparam logic [2:0] RC_NOT_AUTH = 3'd6;
    localparam logic [2:0] RC_BAD_OP   = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EXEC, S_RESP} state_t;

    state_t state_reg, state_next;

    logic [ACC_W-1:0]  acc_tab_reg [NUM_ACC];
    logic [PIN_W-1:0]  pin_tab_reg [NUM_ACC];
    logic [BAL_W-1:0]  bal_tab_reg [NUM_ACC];
    logic [FAIL_W-1:0] fail_reg    [NUM_ACC];
    logic              valid_reg   [NUM_ACC];
    logic              lock_reg    [NUM_ACC];

    logic             live_reg;
    logic [2:0]       op_reg;
    logic [ACC_W-1:0] key_reg;
    logic [PIN_W-1:0] pin_reg;
    logic [AMT_W-1:0] amt_reg;
    logic [IDX_W-1:0] scan_idx_reg;
    logic             found_reg;
    logic [IDX_W-1:0] found_idx_reg;
    logic [IDX_W-1:0] sess_idx_reg;
    logic             authed_reg;
    logic             resp_valid_reg;
    logic [2:0]       resp_code_reg;
    logic [BAL_W-1:0] balance_reg;

    logic accept, prov_ok, exec_fire;

    assign bus.req_ready  = live_reg && (state_reg == S_IDLE);
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_code  = resp_code_reg;
    assign bus.balance    = balance_reg;
    assign bus.authed     = authed_reg;

    assign accept    = bus.req_valid && bus.req_ready && !bus.exit;
    assign prov_ok   = prov_we && (state_reg == S_IDLE) && !authed_reg;
    assign exec_fire = (state_reg == S_EXEC) && !bus.exit;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept)
                        state_next = (bus.op == OP_LOGIN || bus.op == OP_TRANSFER) ? S_SCAN : S_EXEC;
            S_SCAN: if (scan_idx_reg == IDX_W'(NUM_ACC - 1)) state_next = S_EXEC;
            S_EXEC: state_next = S_RESP;
            S_RESP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (bus.exit) state_next = S_IDLE;
    end

    // Operation outcome, evaluated in EXEC from the captured request and scan result.
    logic [2:0]       ex_code;
    logic             ex_out_we, ex_own_we, ex_dest_we;
    logic             ex_fail_inc, ex_login_ok, ex_logout;
    logic [BAL_W-1:0] ex_out_bal, ex_own_bal, ex_dest_bal;
    logic [BAL_W-1:0] own_bal, tgt_bal, amt_ext;
    logic [BAL_W:0]   own_sum, tgt_sum;

    assign own_bal = bal_tab_reg[sess_idx_reg];
    assign tgt_bal = bal_tab_reg[found_idx_reg];
    assign amt_ext = BAL_W'(amt_reg);
    assign own_sum = (BAL_W+1)'(own_bal) + (BAL_W+1)'(amt_reg);
    assign tgt_sum = (BAL_W+1)'(tgt_bal) + (BAL_W+1)'(amt_reg);

    always_comb begin
        ex_code     = RC_OK;
        ex_out_we   = 1'b0;
        ex_own_we   = 1'b0;
        ex_dest_we  = 1'b0;
        ex_fail_inc = 1'b0;
        ex_login_ok = 1'b0;
        ex_logout   = 1'b0;
        ex_out_bal  = own_bal;
        ex_own_bal  = own_bal;
        ex_dest_bal = tgt_sum[BAL_W-1:0];
        case (op_reg)
            OP_LOGIN: begin
                if (!found_reg)                              ex_code = RC_BAD_CRED;
                else if (lock_reg[found_idx_reg])            ex_code = RC_LOCKED;
                else if (pin_tab_reg[found_idx_reg] != pin_reg) begin
                    ex_code     = RC_BAD_CRED;
                    ex_fail_inc = 1'b1;
                end else                                     ex_login_ok = 1'b1;
            end
            OP_BALANCE: begin
                if (!authed_reg) ex_code = RC_NOT_AUTH;
                else             ex_out_we = 1'b1;
            end
            OP_WITHDRAW: begin
                if (!authed_reg)            ex_code = RC_NOT_AUTH;
                else if (amt_ext > own_bal) ex_code = RC_INSUFF;
                else begin
                    ex_own_bal = own_bal - amt_ext;
                    ex_out_bal = ex_own_bal;
                    ex_own_we  = 1'b1;
                    ex_out_we  = 1'b1;
                end
            end
            OP_DEPOSIT: begin
                if (!authed_reg)       ex_code = RC_NOT_AUTH;
                else if (own_sum[BAL_W]) ex_code = RC_OVERFLOW;
                else begin
                    ex_own_bal = own_sum[BAL_W-1:0];
                    ex_out_bal = ex_own_bal;
                    ex_own_we  = 1'b1;
                    ex_out_we  = 1'b1;
                end
            end
            OP_TRANSFER: begin
                if (!authed_reg)                                   ex_code = RC_NOT_AUTH;
                else if (!found_reg || found_idx_reg == sess_idx_reg) ex_code = RC_NO_DEST;
                else if (amt_ext > own_bal)                        ex_code = RC_INSUFF;
                else if (tgt_sum[BAL_W])                           ex_code = RC_OVERFLOW;
                else begin
                    ex_own_bal = own_bal - amt_ext;
                    ex_out_bal = ex_own_bal;
                    ex_own_we  = 1'b1;
                    ex_dest_we = 1'b1;
                    ex_out_we  = 1'b1;
                end
            end
            OP_LOGOUT: ex_logout = 1'b1;
            default:   ex_code = RC_BAD_OP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_reg       <= 1'b0;
            op_reg         <= '0;
            key_reg        <= '0;
            pin_reg        <= '0;
            amt_reg        <= '0;
            scan_idx_reg   <= '0;
            found_reg      <= 1'b0;
            found_idx_reg  <= '0;
            sess_idx_reg   <= '0;
            authed_reg     <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_code_reg  <= '0;
            balance_reg    <= '0;
        end else begin
            live_reg       <= 1'b1;
            resp_valid_reg <= 1'b0;
            if (bus.exit) begin
                authed_reg <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: if (accept) begin
                        op_reg       <= bus.op;
                        key_reg      <= (bus.op == OP_TRANSFER) ? bus.dest_acc : bus.acc_number;
                        pin_reg      <= bus.pin;
                        amt_reg      <= bus.amount;
                        scan_idx_reg <= '0;
                        found_reg    <= 1'b0;
                    end
                    S_SCAN: begin
                        // First hit is kept so the lowest slot wins on duplicates.
                        if (!found_reg && valid_reg[scan_idx_reg] && acc_tab_reg[scan_idx_reg] == key_reg) begin
                            found_reg     <= 1'b1;
                            found_idx_reg <= scan_idx_reg;
                        end
                        scan_idx_reg <= scan_idx_reg + IDX_W'(1);
                    end
                    S_EXEC: begin
                        resp_valid_reg <= 1'b1;
                        resp_code_reg  <= ex_code;
                        if (ex_out_we) balance_reg <= ex_out_bal;
                        if (ex_login_ok) begin
                            authed_reg   <= 1'b1;
                            sess_idx_reg <= found_idx_reg;
                        end
                        if (ex_logout) authed_reg <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_ACC; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi]   <= 1'b0;
                    acc_tab_reg[gi] <= '0;
                    pin_tab_reg[gi] <= '0;
                    bal_tab_reg[gi] <= '0;
                    fail_reg[gi]    <= '0;
                    lock_reg[gi]    <= 1'b0;
                end else if (prov_ok && prov_idx == IDX_W'(gi)) begin
                    valid_reg[gi]   <= 1'b1;
                    acc_tab_reg[gi] <= prov_acc;
                    pin_tab_reg[gi] <= prov_pin;
                    bal_tab_reg[gi] <= BAL_W'(INIT_BAL);
                    fail_reg[gi]    <= '0;
                    lock_reg[gi]    <= 1'b0;
                end else if (exec_fire) begin
                    if (ex_own_we && sess_idx_reg == IDX_W'(gi))
                        bal_tab_reg[gi] <= ex_own_bal;
                    if (ex_dest_we && found_idx_reg == IDX_W'(gi))
                        bal_tab_reg[gi] <= ex_dest_bal;
                    if (found_idx_reg == IDX_W'(gi)) begin
                        if (ex_login_ok) fail_reg[gi] <= '0;
                        if (ex_fail_inc) begin
                            fail_reg[gi] <= fail_reg[gi] + FAIL_W'(1);
                            if (fail_reg[gi] + FAIL_W'(1) >= FAIL_W'(MAX_TRIES))
                                lock_reg[gi] <= 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl: a vector table of requests with
// hand-computed responses, plus hand-written abort sequences.
module tb_atm_session_ctrl;
    localparam int NUM_ACC = 10;
    localparam int IDX_W   = 4;

    localparam logic [2:0] LOGIN = 0, BALANCE = 1, WITHDRAW = 2, DEPOSIT = 3,
                           TRANSFER = 4, LOGOUT = 5;
    localparam logic [2:0] OK = 0, BAD_CRED = 1, LOCKED = 2, INSUFF = 3,
                           OVERFLOW = 4, NO_DEST = 5, NOT_AUTH = 6, BAD_OP = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic prov_we = 1'b0;
    logic [IDX_W-1:0] prov_idx = '0;
    logic [11:0] prov_acc = '0;
    logic [3:0]  prov_pin = '0;

    always #5 clk = ~clk;

    atm_session_if #(.ACC_W(12), .PIN_W(4), .BAL_W(16), .AMT_W(11)) ifc ();

    atm_session_ctrl #(.NUM_ACC(NUM_ACC)) dut (
        .clk      (clk),
        .rst      (rst),
        .prov_we  (prov_we),
        .prov_idx (prov_idx),
        .prov_acc (prov_acc),
        .prov_pin (prov_pin),
        .bus      (ifc)
    );

    typedef struct {
        bit          prov;
        logic [3:0]  pidx;
        logic [2:0]  op;
        logic [11:0] acc;
        logic [3:0]  pin;
        logic [11:0] dest;
        logic [10:0] amt;
        logic [2:0]  code;
        logic [15:0] bal;
        bit          authed;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add_req(logic [2:0] op, logic [11:0] acc, logic [3:0] pin,
                                    logic [11:0] dest, logic [10:0] amt,
                                    logic [2:0] code, logic [15:0] bal, bit authed);
        vec_t v;
        v.prov = 1'b0; v.pidx = '0;
        v.op = op; v.acc = acc; v.pin = pin; v.dest = dest; v.amt = amt;
        v.code = code; v.bal = bal; v.authed = authed;
        vecs.push_back(v);
    endfunction

    function automatic void add_prov(logic [3:0] idx, logic [11:0] acc, logic [3:0] pin);
        vec_t v;
        v.prov = 1'b1; v.pidx = idx; v.acc = acc; v.pin = pin;
        v.op = '0; v.dest = '0; v.amt = '0; v.code = '0; v.bal = '0; v.authed = 1'b0;
        vecs.push_back(v);
    endfunction

    task automatic provision(input logic [3:0] idx, input logic [11:0] acc, input logic [3:0] pin);
        @(negedge clk);
        prov_we = 1'b1; prov_idx = idx; prov_acc = acc; prov_pin = pin;
        @(negedge clk);
        prov_we = 1'b0;
        $display("prov slot %0d acc %0d pin %0d", idx, acc, pin);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ifc.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", ifc.req_ready, 1);
    endtask

    task automatic drive_req(input vec_t v);
        ifc.req_valid = 1'b1; ifc.op = v.op; ifc.acc_number = v.acc; ifc.pin = v.pin;
        ifc.dest_acc = v.dest; ifc.amount = v.amt;
    endtask

    task automatic do_req(input vec_t v, input int i);
        int lat;
        int exp_lat;
        wait_ready();
        drive_req(v);
        @(negedge clk);
        ifc.req_valid = 1'b0;
        lat = 1;
        while (!ifc.resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        exp_lat = (v.op == LOGIN || v.op == TRANSFER) ? NUM_ACC + 2 : 2;
        $display("vec %0d op %0d amt %0d -> code %0d bal %0d authed %0d lat %0d",
                 i, v.op, v.amt, ifc.resp_code, ifc.balance, ifc.authed, lat);
        check($sformatf("latency[%0d]", i), lat, exp_lat);
        check($sformatf("resp_code[%0d]", i), ifc.resp_code, v.code);
        check($sformatf("balance[%0d]", i), ifc.balance, v.bal);
        check($sformatf("authed[%0d]", i), ifc.authed, v.authed);
        @(negedge clk);
        check($sformatf("resp_pulse[%0d]", i), ifc.resp_valid, 0);
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (vecs[i].prov) provision(vecs[i].pidx, vecs[i].acc, vecs[i].pin);
            else              do_req(vecs[i], i);
        end
    endtask

    initial begin
        int split;
        int seen;
        vec_t t;

        ifc.req_valid = 1'b0; ifc.op = '0; ifc.acc_number = '0; ifc.pin = '0;
        ifc.dest_acc = '0; ifc.amount = '0; ifc.exit = 1'b0;

        // Login, lockout and reprovisioning.
        add_prov(3, 2125, 3);
        add_req(LOGIN,   2125, 3, 0, 0, OK,       0, 1);
        add_req(LOGOUT,  0,    0, 0, 0, OK,       0, 0);
        add_req(LOGIN,   2125, 5, 0, 0, BAD_CRED, 0, 0);
        add_req(LOGIN,   2125, 5, 0, 0, BAD_CRED, 0, 0);
        add_req(LOGIN,   2125, 5, 0, 0, BAD_CRED, 0, 0);
        add_req(LOGIN,   2125, 3, 0, 0, LOCKED,   0, 0);
        add_req(BALANCE, 0,    0, 0, 0, NOT_AUTH, 0, 0);
        add_req(3'd6,    0,    0, 0, 0, BAD_OP,   0, 0);
        add_req(LOGIN,   4000, 3, 0, 0, BAD_CRED, 0, 0);
        add_prov(3, 2125, 3);
        add_req(LOGIN,   2125, 3, 0, 0, OK,       0, 1);
        // Withdraw / deposit boundaries.
        add_req(BALANCE, 0, 0, 0, 0,    OK,     500,  1);
        add_req(WITHDRAW,0, 0, 0, 500,  OK,     0,    1);
        add_req(WITHDRAW,0, 0, 0, 1,    INSUFF, 0,    1);
        add_req(DEPOSIT, 0, 0, 0, 2047, OK,     2047, 1);
        add_req(3'd7,    0, 0, 0, 0,    BAD_OP, 2047, 1);
        for (int k = 1; k <= 30; k++)
            add_req(DEPOSIT, 0, 0, 0, 2047, OK, 16'(2047 * (k + 1)), 1);
        add_req(DEPOSIT, 0, 0, 0, 1543, OK,       65000, 1);
        add_req(DEPOSIT, 0, 0, 0, 1000, OVERFLOW, 65000, 1);
        add_req(DEPOSIT, 0, 0, 0, 535,  OK,       65535, 1);
        add_req(DEPOSIT, 0, 0, 0, 0,    OK,       65535, 1);
        add_req(DEPOSIT, 0, 0, 0, 1,    OVERFLOW, 65535, 1);
        add_req(LOGOUT,  0, 0, 0, 0,    OK,       65535, 0);
        // Transfers.
        add_prov(3, 2125, 3);
        add_prov(7, 2910, 7);
        add_req(LOGIN,    2125, 3, 0,    0,   OK,      65535, 1);
        add_req(TRANSFER, 0,    0, 2910, 200, OK,      300,   1);
        add_req(TRANSFER, 0,    0, 1111, 10,  NO_DEST, 300,   1);
        add_req(TRANSFER, 0,    0, 2125, 10,  NO_DEST, 300,   1);
        add_req(TRANSFER, 0,    0, 2910, 301, INSUFF,  300,   1);
        add_req(TRANSFER, 0,    0, 2910, 0,   OK,      300,   1);
        add_req(LOGOUT,   0,    0, 0,    0,   OK,      300,   0);
        add_req(LOGIN,    2910, 7, 0,    0,   OK,      300,   1);
        add_req(BALANCE,  0,    0, 0,    0,   OK,      700,   1);
        add_req(LOGOUT,   0,    0, 0,    0,   OK,      700,   0);
        add_req(LOGIN,    2125, 3, 0,    0,   OK,      700,   1);
        split = vecs.size();
        // After the aborted transfer: session gone, balances untouched.
        add_req(BALANCE,  0,    0, 0, 0, NOT_AUTH, 700, 0);
        add_req(LOGIN,    2125, 3, 0, 0, OK,       700, 1);
        add_req(BALANCE,  0,    0, 0, 0, OK,       300, 1);
        add_req(LOGOUT,   0,    0, 0, 0, OK,       300, 0);
        add_req(LOGIN,    2910, 7, 0, 0, OK,       300, 1);
        add_req(BALANCE,  0,    0, 0, 0, OK,       700, 1);

        repeat (3) @(negedge clk);
        check("rst_req_ready",  ifc.req_ready,  0);
        check("rst_resp_valid", ifc.resp_valid, 0);
        check("rst_resp_code",  ifc.resp_code,  0);
        check("rst_balance",    ifc.balance,    0);
        check("rst_authed",     ifc.authed,     0);
        rst = 1'b0;
        #1;
        check("ready_before_edge", ifc.req_ready, 0);
        @(negedge clk);
        check("ready_after_rst", ifc.req_ready, 1);

        run_range(0, split);

        // Abort a transfer in the middle of its scan.
        wait_ready();
        t.prov = 0; t.pidx = 0; t.op = TRANSFER; t.acc = 0; t.pin = 0; t.dest = 2910;
        t.amt = 50; t.code = 0; t.bal = 0; t.authed = 0;
        drive_req(t);
        @(negedge clk);
        ifc.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        ifc.exit = 1'b1;
        @(negedge clk);
        ifc.exit = 1'b0;
        check("exit_authed", ifc.authed, 0);
        seen = 0;
        repeat (16) begin
            if (ifc.resp_valid) seen = 1;
            @(negedge clk);
        end
        $display("exit mid-scan: resp seen %0d authed %0d ready %0d", seen, ifc.authed, ifc.req_ready);
        check("exit_no_resp", seen, 0);
        check("exit_ready",   ifc.req_ready, 1);

        // A request presented together with exit must not be accepted.
        t.op = BALANCE;
        drive_req(t);
        ifc.exit = 1'b1;
        @(negedge clk);
        ifc.req_valid = 1'b0;
        ifc.exit = 1'b0;
        seen = 0;
        repeat (6) begin
            if (ifc.resp_valid) seen = 1;
            @(negedge clk);
        end
        $display("req with exit: resp seen %0d", seen);
        check("exit_blocks_accept", seen, 0);

        run_range(split, vecs.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
